// File: rtl/mc_port_sched.sv
// rtl/mc_port_sched.sv - round-robin multi-core request port scheduler with response steering and drain
// One registered request slot toward the MC; per-core outstanding counters gate eligibility.
module mc_port_sched #(
   parameter int NUM_CORE        = 4,
   parameter int NB_COREID       = 2,
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int MAX_OUTS        = 7,
   parameter int PKT_W           = 122 + MC_RTNCTL_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORE-1:0]         core_rq_vld,
   input  logic [NUM_CORE*PKT_W-1:0]   core_rq_pkt,
   output logic [NUM_CORE-1:0]         core_rq_gnt,
   output logic                        mc_rq_vld,
   output logic [PKT_W-1:0]            mc_rq_pkt,
   input  logic                        mc_rq_stall,
   input  logic                        mc_rs_vld,
   input  logic [MC_RTNCTL_WIDTH-1:0]  mc_rs_rtnctl,
   output logic                        mc_rs_stall,
   output logic [NUM_CORE-1:0]         core_rs_vld,
   input  logic [NUM_CORE-1:0]         core_rs_stall,
   input  logic                        drain_req,
   output logic                        drain_done,
   output logic                        outs_err
);
   localparam int CNT_W = $clog2(MAX_OUTS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);
   // rtnctl sits above size/vadr/scmd/cmd (57 bits); the core id occupies its top bits
   localparam int ID_LSB = 57 + MC_RTNCTL_WIDTH - NB_COREID;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t               r_state;
   logic [NB_COREID-1:0] r_rr_ptr;
   logic                 r_out_vld;
   logic [PKT_W-1:0]     r_out_pkt;
   logic [CNT_W-1:0]     r_cnt [NUM_CORE];
   logic                 r_err;
   logic                 r_drain_done;

   logic                 w_slot_free;
   logic [NUM_CORE-1:0]  w_elig;
   logic [NUM_CORE-1:0]  w_gnt;
   logic                 w_any_gnt;
   logic [NB_COREID-1:0] w_gnt_id;
   logic [PKT_W-1:0]     w_gnt_pkt;
   logic [NB_COREID-1:0] w_rs_tgt;
   logic                 w_rs_tgt_ok;
   logic                 w_rs_dlv;
   logic [CNT_W-1:0]     w_cnt_nxt [NUM_CORE];
   logic                 w_err_set;
   logic                 w_all_zero_nxt;
   logic                 w_out_vld_nxt;

   assign w_slot_free = !r_out_vld || !mc_rq_stall;

   always_comb begin
      for (int i = 0; i < NUM_CORE; i++) begin
         w_elig[i] = core_rq_vld[i] && (r_cnt[i] < MAX_CNT) && (r_state == S_RUN) && w_slot_free;
      end
   end

   // Search starts at the rr pointer; the first eligible core wins
   always_comb begin
      int idx;
      w_any_gnt = 1'b0;
      w_gnt_id  = '0;
      w_gnt_pkt = '0;
      w_gnt     = '0;
      for (int k = 0; k < NUM_CORE; k++) begin
         idx = (int'(r_rr_ptr) + k) % NUM_CORE;
         if (!w_any_gnt && w_elig[idx]) begin
            w_any_gnt = 1'b1;
            w_gnt_id  = NB_COREID'(idx);
            w_gnt_pkt = core_rq_pkt[idx*PKT_W +: PKT_W];
         end
      end
      if (w_any_gnt) begin
         w_gnt[w_gnt_id] = 1'b1;
         w_gnt_pkt[ID_LSB +: NB_COREID] = w_gnt_id;
      end
   end

   assign core_rq_gnt = rst_n ? w_gnt : '0;

   assign w_rs_tgt    = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: NB_COREID];
   assign w_rs_tgt_ok = int'(w_rs_tgt) < NUM_CORE;
   assign mc_rs_stall = w_rs_tgt_ok ? core_rs_stall[w_rs_tgt] : 1'b0;
   assign w_rs_dlv    = mc_rs_vld && !mc_rs_stall;

   always_comb begin
      core_rs_vld = '0;
      if (w_rs_tgt_ok) core_rs_vld[w_rs_tgt] = mc_rs_vld;
   end

   // A delivered response to an idle counter is an underflow: count pins at zero and flags
   always_comb begin
      logic dec;
      w_err_set      = 1'b0;
      w_all_zero_nxt = 1'b1;
      for (int i = 0; i < NUM_CORE; i++) begin
         dec          = w_rs_dlv && (w_rs_tgt == NB_COREID'(i));
         w_cnt_nxt[i] = r_cnt[i];
         if (w_gnt[i] && !dec) begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end else if (dec && !w_gnt[i]) begin
            if (r_cnt[i] == '0) w_err_set = 1'b1;
            else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
         end
         if (w_cnt_nxt[i] != '0) w_all_zero_nxt = 1'b0;
      end
   end

   assign w_out_vld_nxt = w_any_gnt || (r_out_vld && mc_rq_stall);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_out_pkt <= '0;
         r_rr_ptr  <= '0;
         r_err     <= 1'b0;
         for (int i = 0; i < NUM_CORE; i++) r_cnt[i] <= '0;
      end else begin
         r_out_vld <= w_out_vld_nxt;
         if (w_any_gnt) begin
            r_out_pkt <= w_gnt_pkt;
            r_rr_ptr  <= (int'(w_gnt_id) == NUM_CORE - 1) ? '0 : w_gnt_id + 1'b1;
         end
         if (w_err_set) r_err <= 1'b1;
         for (int i = 0; i < NUM_CORE; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   // DONE is entered the edge the last outstanding item retires, so drain_done follows it directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_RUN;
         r_drain_done <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (drain_req) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!w_out_vld_nxt && w_all_zero_nxt) begin
                  r_state      <= S_DONE;
                  r_drain_done <= 1'b1;
               end
            end
            S_DONE: begin
               if (!drain_req) begin
                  r_state      <= S_RUN;
                  r_drain_done <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_RUN;
               r_drain_done <= 1'b0;
            end
         endcase
      end
   end

   assign mc_rq_vld  = r_out_vld;
   assign mc_rq_pkt  = r_out_pkt;
   assign drain_done = r_drain_done;
   assign outs_err   = r_err;

endmodule

// File: tb/tb_mc_port_sched.sv
// tb/tb_mc_port_sched.sv - directed table-driven bench for mc_port_sched
// Inputs change 1ns after posedge; all outputs are compared at the negedge.
module tb_mc_port_sched;
   localparam int NC  = 4;
   localparam int RW  = 32;
   localparam int PW  = 122 + RW;
   localparam int IDL = 57 + RW - 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NC-1:0]  core_rq_vld;
   logic [PW-1:0]  pkts [NC];
   logic [NC*PW-1:0] core_rq_pkt;
   logic [NC-1:0]  core_rq_gnt;
   logic           mc_rq_vld;
   logic [PW-1:0]  mc_rq_pkt;
   logic           mc_rq_stall;
   logic           mc_rs_vld;
   logic [RW-1:0]  mc_rs_rtnctl;
   logic           mc_rs_stall;
   logic [NC-1:0]  core_rs_vld;
   logic [NC-1:0]  core_rs_stall;
   logic           drain_req;
   logic           drain_done;
   logic           outs_err;

   int n_cmp = 0;
   int n_bad = 0;

   assign core_rq_pkt = {pkts[3], pkts[2], pkts[1], pkts[0]};

   always #5 clk = ~clk;

   mc_port_sched dut (
      .clk(clk), .rst_n(rst_n),
      .core_rq_vld(core_rq_vld), .core_rq_pkt(core_rq_pkt), .core_rq_gnt(core_rq_gnt),
      .mc_rq_vld(mc_rq_vld), .mc_rq_pkt(mc_rq_pkt), .mc_rq_stall(mc_rq_stall),
      .mc_rs_vld(mc_rs_vld), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
      .core_rs_vld(core_rs_vld), .core_rs_stall(core_rs_stall),
      .drain_req(drain_req), .drain_done(drain_done), .outs_err(outs_err)
   );

   typedef struct packed {
      logic [3:0] rq;
      logic       stall;
      logic       rs;
      logic [1:0] rs_id;
      logic [3:0] rs_stall;
      logic [3:0] e_gnt;
      logic       e_mcv;
      logic [1:0] e_mc_id;
      logic [3:0] e_rsv;
      logic       e_rss;
   } vec_t;

   vec_t vt [18];

   function automatic logic [PW-1:0] mk_pkt(int c, int s, logic [1:0] top);
      logic [RW-1:0] rc;
      rc = {top, 22'h15A5A5, 8'(s)};
      return {1'(s & 1), 16'hC0DE, 16'(c), 32'(s), rc, 2'(c), 48'h1000_0000 + 48'(s), 4'hA, 3'(c)};
   endfunction

   function automatic logic [PW-1:0] core_pkt(int c, int s);
      return mk_pkt(c, s, ~2'(c));
   endfunction

   function automatic logic [PW-1:0] exp_pkt(int c, int s);
      return mk_pkt(c, s, 2'(c));
   endfunction

   function automatic vec_t mkv(logic [3:0] rq, logic st, logic rs, logic [1:0] rid, logic [3:0] rss,
                                logic [3:0] g, logic mv, logic [1:0] mid, logic [3:0] rv, logic rsst);
      vec_t v;
      v.rq = rq; v.stall = st; v.rs = rs; v.rs_id = rid; v.rs_stall = rss;
      v.e_gnt = g; v.e_mcv = mv; v.e_mc_id = mid; v.e_rsv = rv; v.e_rss = rsst;
      return v;
   endfunction

   task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      core_rq_vld = '0; mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_rtnctl = '0;
      core_rs_stall = '0; drain_req = 1'b0;
   endtask

   task automatic set_rs(logic v, int id);
      mc_rs_vld = v;
      mc_rs_rtnctl = {2'(id), 30'h0ABC_1234};
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 1'b0;
      #2;
      check("rst_mc_vld", PW'(mc_rq_vld), PW'(0));
      check("rst_done", PW'(drain_done), PW'(0));
      check("rst_err", PW'(outs_err), PW'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      for (int c = 0; c < NC; c++) pkts[c] = core_pkt(c, 0);

      //         rq    st rs id rss     gnt   mv id  rsv   rss
      vt[0]  = mkv(4'hF, 0, 0, 0, 4'h0, 4'h1, 0, 0, 4'h0, 0);
      vt[1]  = mkv(4'hF, 0, 0, 0, 4'h0, 4'h2, 1, 0, 4'h0, 0);
      vt[2]  = mkv(4'hF, 0, 0, 0, 4'h0, 4'h4, 1, 1, 4'h0, 0);
      vt[3]  = mkv(4'hF, 0, 0, 0, 4'h0, 4'h8, 1, 2, 4'h0, 0);
      vt[4]  = mkv(4'hF, 0, 0, 0, 4'h0, 4'h1, 1, 3, 4'h0, 0);
      vt[5]  = mkv(4'h0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0);
      vt[6]  = mkv(4'h2, 1, 0, 0, 4'h0, 4'h2, 0, 0, 4'h0, 0);
      vt[7]  = mkv(4'h0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0);
      vt[8]  = mkv(4'h4, 1, 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0);
      vt[9]  = mkv(4'h4, 0, 0, 0, 4'h0, 4'h4, 1, 1, 4'h0, 0);
      vt[10] = mkv(4'h0, 0, 0, 0, 4'h0, 4'h0, 1, 2, 4'h0, 0);
      vt[11] = mkv(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0);
      vt[12] = mkv(4'h0, 0, 1, 3, 4'h8, 4'h0, 0, 0, 4'h8, 1);
      vt[13] = mkv(4'h0, 0, 1, 3, 4'h8, 4'h0, 0, 0, 4'h8, 1);
      vt[14] = mkv(4'h0, 0, 1, 3, 4'h8, 4'h0, 0, 0, 4'h8, 1);
      vt[15] = mkv(4'h0, 0, 1, 3, 4'h0, 4'h0, 0, 0, 4'h8, 0);
      vt[16] = mkv(4'h0, 0, 1, 0, 4'h8, 4'h0, 0, 0, 4'h1, 0);
      vt[17] = mkv(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0);

      // Round-robin, stall hold, response steering
      do_reset();
      for (int i = 0; i < 18; i++) begin
         core_rq_vld = vt[i].rq; mc_rq_stall = vt[i].stall;
         set_rs(vt[i].rs, int'(vt[i].rs_id)); core_rs_stall = vt[i].rs_stall;
         @(negedge clk);
         check($sformatf("v%0d_gnt", i), PW'(core_rq_gnt), PW'(vt[i].e_gnt));
         check($sformatf("v%0d_mcv", i), PW'(mc_rq_vld), PW'(vt[i].e_mcv));
         if (vt[i].e_mcv)
            check($sformatf("v%0d_id", i), PW'(mc_rq_pkt[IDL +: 2]), PW'(vt[i].e_mc_id));
         check($sformatf("v%0d_rsv", i), PW'(core_rs_vld), PW'(vt[i].e_rsv));
         check($sformatf("v%0d_rss", i), PW'(mc_rs_stall), PW'(vt[i].e_rss));
         check($sformatf("v%0d_err", i), PW'(outs_err), PW'(0));
         next_cycle();
      end

      // Packet held stable under stall; next grant lands the cycle stall drops
      do_reset();
      pkts[2] = core_pkt(2, 5); core_rq_vld = 4'h4;
      @(negedge clk); check("st_gnt0", PW'(core_rq_gnt), PW'(4'h4));
      next_cycle();
      pkts[2] = core_pkt(2, 6); mc_rq_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("st_pkt%0d", k), mc_rq_pkt, exp_pkt(2, 5));
         check($sformatf("st_vld%0d", k), PW'(mc_rq_vld), PW'(1));
         check($sformatf("st_gnt%0d", k), PW'(core_rq_gnt), PW'(0));
         next_cycle();
      end
      mc_rq_stall = 1'b0;
      @(negedge clk);
      check("st_regrant", PW'(core_rq_gnt), PW'(4'h4));
      check("st_last", mc_rq_pkt, exp_pkt(2, 5));
      next_cycle();
      core_rq_vld = '0;
      @(negedge clk); check("st_new", mc_rq_pkt, exp_pkt(2, 6));
      next_cycle();

      // Outstanding limit on core 1
      do_reset();
      core_rq_vld = 4'h2;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); check($sformatf("mx_gnt%0d", k), PW'(core_rq_gnt), PW'(4'h2));
         next_cycle();
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); check($sformatf("mx_blk%0d", k), PW'(core_rq_gnt), PW'(0));
         next_cycle();
      end
      set_rs(1'b1, 1);
      @(negedge clk);
      check("mx_rsv", PW'(core_rs_vld), PW'(4'h2));
      check("mx_blk_rs", PW'(core_rq_gnt), PW'(0));
      next_cycle();
      set_rs(1'b0, 0);
      @(negedge clk); check("mx_resume", PW'(core_rq_gnt), PW'(4'h2));
      next_cycle();
      @(negedge clk); check("mx_full", PW'(core_rq_gnt), PW'(0));
      next_cycle();

      // Same-cycle grant and delivery on core 3 keeps the count
      do_reset();
      core_rq_vld = 4'h8;
      @(negedge clk); check("sc_gnt0", PW'(core_rq_gnt), PW'(4'h8));
      next_cycle();
      set_rs(1'b1, 3);
      @(negedge clk);
      check("sc_gnt1", PW'(core_rq_gnt), PW'(4'h8));
      check("sc_rsv", PW'(core_rs_vld), PW'(4'h8));
      next_cycle();
      core_rq_vld = '0;
      @(negedge clk); check("sc_err_a", PW'(outs_err), PW'(0));
      next_cycle();
      @(negedge clk); check("sc_err_b", PW'(outs_err), PW'(0));
      next_cycle();
      set_rs(1'b0, 0);
      @(negedge clk); check("sc_err_c", PW'(outs_err), PW'(1));
      next_cycle();

      // Drain with two outstanding on core 0
      do_reset();
      core_rq_vld = 4'h1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); check($sformatf("dr_gnt%0d", k), PW'(core_rq_gnt), PW'(4'h1));
         next_cycle();
      end
      core_rq_vld = '0; drain_req = 1'b1;
      next_cycle();
      core_rq_vld = 4'hF;
      @(negedge clk);
      check("dr_nogrant", PW'(core_rq_gnt), PW'(0));
      check("dr_done0", PW'(drain_done), PW'(0));
      next_cycle();
      set_rs(1'b1, 0);
      @(negedge clk); check("dr_done1", PW'(drain_done), PW'(0));
      next_cycle();
      set_rs(1'b0, 0);
      @(negedge clk); check("dr_done2", PW'(drain_done), PW'(0));
      next_cycle();
      set_rs(1'b1, 0);
      @(negedge clk); check("dr_done3", PW'(drain_done), PW'(0));
      next_cycle();
      set_rs(1'b0, 0);
      @(negedge clk);
      check("dr_done_hi", PW'(drain_done), PW'(1));
      check("dr_gnt_done", PW'(core_rq_gnt), PW'(0));
      next_cycle();
      drain_req = 1'b0;
      @(negedge clk);
      check("dr_done_hold", PW'(drain_done), PW'(1));
      check("dr_gnt_hold", PW'(core_rq_gnt), PW'(0));
      next_cycle();
      @(negedge clk);
      check("dr_done_lo", PW'(drain_done), PW'(0));
      check("dr_resume", PW'(core_rq_gnt), PW'(4'h2));
      next_cycle();

      // Reset mid-transaction, then underflow and async clear
      do_reset();
      core_rq_vld = 4'h4;
      @(negedge clk); check("er_gnt", PW'(core_rq_gnt), PW'(4'h4));
      next_cycle();
      core_rq_vld = '0;
      @(negedge clk); check("er_mcv", PW'(mc_rq_vld), PW'(1));
      #1 rst_n = 1'b0;
      #1 check("er_async_mcv", PW'(mc_rq_vld), PW'(0));
      next_cycle();
      rst_n = 1'b1;
      set_rs(1'b1, 2);
      @(negedge clk);
      check("er_rsv", PW'(core_rs_vld), PW'(4'h4));
      check("er_err0", PW'(outs_err), PW'(0));
      next_cycle();
      set_rs(1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); check($sformatf("er_sticky%0d", k), PW'(outs_err), PW'(1));
         next_cycle();
      end
      #2 rst_n = 1'b0;
      #1 check("er_async_clr", PW'(outs_err), PW'(0));
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk); check("er_after", PW'(outs_err), PW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
